// File: rtl/framebuffer_reader.sv
// framebuffer_reader: Avalon-MM scan-out of an RGB565 framebuffer into an Avalon-ST pixel stream.
// Optional: define CONTINUOUS_SCAN_EN to rescan frames back-to-back without new start pulses.
module framebuffer_reader #(
   parameter int H_RESOLUTION = 320,
   parameter int V_RESOLUTION = 240,
   parameter int FIFO_DEPTH   = 16,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_address,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] m_address,
   output logic                  m_read,
   input  logic                  m_waitrequest,
   input  logic [15:0]           m_readdata,
   input  logic                  m_readdatavalid,
   output logic [15:0]           pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_sop,
   output logic                  pix_eop
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [8:0] COL_LAST = 9'(H_RESOLUTION - 1);
   localparam logic [7:0] ROW_LAST = 8'(V_RESOLUTION - 1);
   localparam logic [PW+1:0] CREDITS = (PW+2)'(FIFO_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [7:0]  req_row, out_row;
   logic [8:0]  req_col, out_col;
   logic [PW:0] fifo_count, outstanding;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [15:0] mem [FIFO_DEPTH];
   logic start_ok, req_acc, req_last, credit_ok;
   logic push, pop, out_last, frame_end;

   assign start_ok  = start && (state == IDLE) && !done;
   assign req_acc   = m_read && !m_waitrequest;
   assign req_last  = (req_row == ROW_LAST) && (req_col == COL_LAST);
   assign out_last  = (out_row == ROW_LAST) && (out_col == COL_LAST);
   assign credit_ok = ((PW+2)'(fifo_count) + (PW+2)'(outstanding)) < CREDITS;
   assign push      = m_readdatavalid && (state != IDLE) && (outstanding != '0);
   assign pop       = pix_valid && pix_ready;
   assign frame_end = pop && out_last && (state == DRAIN);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start_ok) state_nxt = FETCH;
         FETCH: if (req_acc && req_last) state_nxt = DRAIN;
         DRAIN: begin
`ifdef CONTINUOUS_SCAN_EN
            if (frame_end) state_nxt = FETCH;
`else
            if (frame_end) state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Credit check stays true once raised, so a stalled request holds stable
   always_comb begin
      busy      = (state != IDLE);
      m_read    = (state == FETCH) && credit_ok;
      m_address = '0;
      if (m_read)
         m_address = base_q + ADDR_WIDTH'({req_row, req_col, 1'b0});
   end

`ifdef CONTINUOUS_SCAN_EN
   logic [ADDR_WIDTH-1:0] base_nxt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_nxt <= '0;
         base_q   <= '0;
      end else begin
         if (start) base_nxt <= base_address & ALIGN;
         if (start_ok)
            base_q <= base_address & ALIGN;
         else if (frame_end)
            base_q <= start ? (base_address & ALIGN) : base_nxt;
      end
   end
`else
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)      base_q <= '0;
      else if (start_ok) base_q <= base_address & ALIGN;
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_row <= '0;
         req_col <= '0;
      end else if (start_ok) begin
         req_row <= '0;
         req_col <= '0;
      end else if (req_acc) begin
         if (req_col == COL_LAST) begin
            req_col <= '0;
            req_row <= (req_row == ROW_LAST) ? '0 : req_row + 8'd1;
         end else begin
            req_col <= req_col + 9'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_row <= '0;
         out_col <= '0;
      end else if (start_ok) begin
         out_row <= '0;
         out_col <= '0;
      end else if (pop) begin
         if (out_col == COL_LAST) begin
            out_col <= '0;
            out_row <= (out_row == ROW_LAST) ? '0 : out_row + 8'd1;
         end else begin
            out_col <= out_col + 9'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
      end else begin
         unique case ({req_acc, push})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && (fifo_count != FULL || pop))
         mem[wr_ptr] <= m_readdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push && (fifo_count != FULL || pop)) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop && fifo_count != FULL)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push)
            fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) done <= 1'b0;
      else          done <= frame_end;
   end

   assign pix_valid = (fifo_count != '0);
   assign pix_data  = pix_valid ? mem[rd_ptr] : '0;
   assign pix_sop   = pix_valid && (out_row == '0) && (out_col == '0);
   assign pix_eop   = pix_valid && out_last;

endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader: directed bench for framebuffer_reader (4x2 frame, 4-entry FIFO).
// The slave returns data derived from the address after a programmable latency.
module tb_framebuffer_reader;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int FD = 4;
   localparam int AW = 32;
   localparam logic [31:0] B1 = 32'h0800_0000;
   localparam logic [31:0] B2 = 32'h0C00_0000;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic          busy, done, m_read, pix_valid, pix_sop, pix_eop;
   logic [AW-1:0] m_address;
   logic          m_waitrequest = 1'b0;
   logic [15:0]   m_readdata = '0;
   logic          m_readdatavalid = 1'b0;
   logic [15:0]   pix_data;
   logic          pix_ready = 1'b0;

   framebuffer_reader #(
      .H_RESOLUTION(H), .V_RESOLUTION(V), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .base_address(base_address), .busy(busy), .done(done),
      .m_address(m_address), .m_read(m_read),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_sop(pix_sop), .pix_eop(pix_eop)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int lat = 1;
   logic [31:0] acc_q[$];
   logic [15:0] pix_q[$];
   logic        sop_q[$];
   logic        eop_q[$];
   logic        pv[8];
   logic [15:0] pd[8];

   function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i);
      return b + 32'((i / H) << 10) + 32'((i % H) << 1);
   endfunction

   function automatic logic [15:0] pix_of(input logic [31:0] a);
      return a[16:1] ^ 16'hC35A;
   endfunction

   // Memory model: pipeline of returns, lat cycles after accept
   always @(posedge clock) begin
      logic acc;
      logic [31:0] a;
      acc = m_read && !m_waitrequest;
      a = m_address;
      #1;
      for (int i = 0; i < 7; i++) begin
         pv[i] = pv[i+1];
         pd[i] = pd[i+1];
      end
      pv[7] = 1'b0;
      pd[7] = '0;
      if (acc) begin
         pv[lat-1] = 1'b1;
         pd[lat-1] = pix_of(a);
      end
      m_readdatavalid = pv[0];
      m_readdata = pd[0];
   end

   always @(negedge clock) begin
      if (m_read && !m_waitrequest) acc_q.push_back(m_address);
      if (pix_valid && pix_ready) begin
         pix_q.push_back(pix_data);
         sop_q.push_back(pix_sop);
         eop_q.push_back(pix_eop);
      end
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      acc_q.delete();
      pix_q.delete();
      sop_q.delete();
      eop_q.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic [31:0] b);
      start = 1'b1;
      base_address = b;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && done_cnt < target; i++) tick();
      if (done_cnt >= target) ok = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, m_read, pix_valid, pix_sop, pix_eop} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {busy, done, m_read, pix_valid, pix_sop, pix_eop});
      end
      n_checks++;
      if (m_address !== '0 || pix_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h expected 0/0", m_address, pix_data);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      clear_log();
      lat = 1;
      pix_ready = 1'b1;
      pulse_start(B1);
      wait_done(1, 200, ok);
      repeat (3) tick();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_timeout: got done=%0d expected 1", done_cnt);
      end
      n_checks++;
      if (acc_q.size() != 8) begin
         n_fail++;
         $display("FAIL basic_nreq: got %0d expected 8", acc_q.size());
      end
      for (int i = 0; i < acc_q.size() && i < 8; i++) begin
         n_checks++;
         if (acc_q[i] !== exp_addr(B1, i)) begin
            n_fail++;
            $display("FAIL basic_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(B1, i));
         end
      end
      n_checks++;
      if (pix_q.size() != 8) begin
         n_fail++;
         $display("FAIL basic_npix: got %0d expected 8", pix_q.size());
      end
      for (int i = 0; i < pix_q.size() && i < 8; i++) begin
         n_checks++;
         if (pix_q[i] !== pix_of(exp_addr(B1, i)) || sop_q[i] !== (i == 0) || eop_q[i] !== (i == 7)) begin
            n_fail++;
            $display("FAIL basic_pix[%0d]: got %h sop=%b eop=%b expected %h sop=%b eop=%b",
                     i, pix_q[i], sop_q[i], eop_q[i], pix_of(exp_addr(B1, i)), i == 0, i == 7);
         end
      end
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end: got done=%0d busy=%b expected 1/0", done_cnt, busy);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_log();
      lat = 1;
      pix_ready = 1'b0;
      pulse_start(B1);
      repeat (30) tick();
      n_checks++;
      if (acc_q.size() < 1 || acc_q.size() > FD) begin
         n_fail++;
         $display("FAIL bp_nreq: got %0d expected 1..%0d", acc_q.size(), FD);
      end
      n_checks++;
      if (m_read !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_read: got %b expected 0", m_read);
      end
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== pix_of(B1) || pix_sop !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_head: got v=%b %h sop=%b expected v=1 %h sop=1",
                  pix_valid, pix_data, pix_sop, pix_of(B1));
      end
      tick();
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== pix_of(B1)) begin
         n_fail++;
         $display("FAIL bp_hold: got v=%b %h expected v=1 %h", pix_valid, pix_data, pix_of(B1));
      end
      pix_ready = 1'b1;
      wait_done(1, 200, ok);
      repeat (3) tick();
      n_checks++;
      if (!ok || pix_q.size() != 8) begin
         n_fail++;
         $display("FAIL bp_end: got done=%0d npix=%0d expected 1/8", done_cnt, pix_q.size());
      end
      for (int i = 0; i < pix_q.size() && i < 8; i++) begin
         n_checks++;
         if (pix_q[i] !== pix_of(exp_addr(B1, i))) begin
            n_fail++;
            $display("FAIL bp_pix[%0d]: got %h expected %h", i, pix_q[i], pix_of(exp_addr(B1, i)));
         end
      end
   endtask

   task automatic test_waitrequest();
      bit ok;
      clear_log();
      lat = 1;
      pix_ready = 1'b1;
      pulse_start(B1);
      tick();
      m_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (m_read !== 1'b1 || m_address !== 32'h0800_0002) begin
            n_fail++;
            $display("FAIL wr_hold[%0d]: got rd=%b %h expected rd=1 08000002", i, m_read, m_address);
         end
         tick();
      end
      m_waitrequest = 1'b0;
      wait_done(1, 200, ok);
      repeat (3) tick();
      n_checks++;
      if (!ok || acc_q.size() != 8) begin
         n_fail++;
         $display("FAIL wr_nreq: got done=%0d nreq=%0d expected 1/8", done_cnt, acc_q.size());
      end
      for (int i = 0; i < acc_q.size() && i < 8; i++) begin
         n_checks++;
         if (acc_q[i] !== exp_addr(B1, i)) begin
            n_fail++;
            $display("FAIL wr_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(B1, i));
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit ok;
      clear_log();
      lat = 3;
      pix_ready = 1'b1;
      pulse_start(B1);
      tick();
      tick();
      n_checks++;
      if (acc_q.size() != 2 || pix_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_pre: got nreq=%0d v=%b expected 2/0", acc_q.size(), pix_valid);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, m_read, pix_valid, pix_sop, pix_eop} !== 6'b0 || m_address !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got %b %h expected 000000 0",
                  {busy, done, m_read, pix_valid, pix_sop, pix_eop}, m_address);
      end
      tick();
      reset_n = 1'b1;
      repeat (6) tick();
      n_checks++;
      if (pix_valid !== 1'b0 || busy !== 1'b0 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL mid_late: got v=%b busy=%b done=%0d expected 0/0/0", pix_valid, busy, done_cnt);
      end
      clear_log();
      lat = 1;
      pulse_start(B2);
      wait_done(1, 200, ok);
      repeat (3) tick();
      n_checks++;
      if (!ok || pix_q.size() != 8) begin
         n_fail++;
         $display("FAIL mid_frame: got done=%0d npix=%0d expected 1/8", done_cnt, pix_q.size());
      end
      for (int i = 0; i < pix_q.size() && i < 8; i++) begin
         n_checks++;
         if (pix_q[i] !== pix_of(exp_addr(B2, i))) begin
            n_fail++;
            $display("FAIL mid_pix[%0d]: got %h expected %h", i, pix_q[i], pix_of(exp_addr(B2, i)));
         end
      end
   endtask

   task automatic test_start_while_busy();
      clear_log();
      lat = 1;
      pix_ready = 1'b1;
      pulse_start(B1);
      repeat (3) tick();
      pulse_start(B2);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (done) begin
            start = 1'b1;
            base_address = B2;
            tick();
            start = 1'b0;
            break;
         end
      end
      repeat (6) tick();
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL swb_end: got done=%0d busy=%b expected 1/0", done_cnt, busy);
      end
      n_checks++;
      if (pix_q.size() != 8 || acc_q.size() != 8) begin
         n_fail++;
         $display("FAIL swb_count: got npix=%0d nreq=%0d expected 8/8", pix_q.size(), acc_q.size());
      end
      for (int i = 0; i < acc_q.size() && i < 8; i++) begin
         n_checks++;
         if (acc_q[i] !== exp_addr(B1, i)) begin
            n_fail++;
            $display("FAIL swb_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(B1, i));
         end
      end
   endtask

`ifdef CONTINUOUS_SCAN_EN
   task automatic test_continuous();
      bit dropped;
      clear_log();
      lat = 1;
      pix_ready = 1'b1;
      dropped = 1'b0;
      pulse_start(B1);
      for (int i = 0; i < 400 && done_cnt < 3; i++) begin
         if (busy !== 1'b1) dropped = 1'b1;
         tick();
      end
      n_checks++;
      if (dropped || done_cnt != 3) begin
         n_fail++;
         $display("FAIL cont_busy: got dropped=%b done=%0d expected 0/3", dropped, done_cnt);
      end
      n_checks++;
      if (pix_q.size() < 24) begin
         n_fail++;
         $display("FAIL cont_npix: got %0d expected 24", pix_q.size());
      end
      for (int i = 0; i < pix_q.size() && i < 24; i++) begin
         n_checks++;
         if (pix_q[i] !== pix_of(exp_addr(B1, i % 8)) || sop_q[i] !== (i % 8 == 0)) begin
            n_fail++;
            $display("FAIL cont_pix[%0d]: got %h sop=%b expected %h sop=%b",
                     i, pix_q[i], sop_q[i], pix_of(exp_addr(B1, i % 8)), i % 8 == 0);
         end
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) begin
         pv[i] = 1'b0;
         pd[i] = '0;
      end
      test_reset();
`ifdef CONTINUOUS_SCAN_EN
      test_continuous();
`else
      test_basic();
      test_backpressure();
      test_waitrequest();
      test_reset_midframe();
      test_start_while_busy();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/framebuffer_reader.md
Name: framebuffer_reader

Overview:
Avalon-MM read master that scans a 16-bit RGB565 framebuffer out of on-chip RAM, in the layout the voxel GPU writes: pixel (row, col) at base + {row[7:0], col[8:0], 1'b0}.
It converts the pixels into an Avalon-ST pixel stream for the video output path, raster order.
It sits between the OCRAM arbiter and the display pipeline, mirroring the GPU's m1 write master on the read side.

Parameters:
H_RESOLUTION, 320, pixels per row (1..512)
V_RESOLUTION, 240, rows per frame (1..256)
FIFO_DEPTH, 16, pixel buffer entries; power of two, >= 2
ADDR_WIDTH, 32, master address width

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a frame; ignored while busy
base_address  in  ADDR_WIDTH  framebuffer base; sampled on accepted start; bit 0 ignored (treated as 0)
busy  out  1  high from accepted start until last pixel accepted on stream
done  out  1  one-cycle pulse on the cycle after the last pixel is accepted
m_address  out  ADDR_WIDTH  read address
m_read  out  1  read request
m_waitrequest  in  1  slave stall
m_readdata  in  16  returned pixel
m_readdatavalid  in  1  return strobe, in request order
pix_data  out  16  stream pixel
pix_valid  out  1  stream valid
pix_ready  in  1  sink ready
pix_sop  out  1  high with pixel (0,0)
pix_eop  out  1  high with pixel (V-1, H-1)

Behaviour:
- Reset (reset_n low, asynchronous):
  - all outputs 0, FSM IDLE, FIFO empty, counters 0, outstanding count 0.
  - Reset mid-frame aborts immediately; no done pulse.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on start: latch base, clear row/col request counters, busy=1.
  - FETCH -> DRAIN when the read for (V-1, H-1) is accepted (m_read & !m_waitrequest).
  - DRAIN -> IDLE when the eop pixel is accepted (pix_valid & pix_ready): done=1 for one cycle, busy=0.
- Request side:
  - m_address = base + {row, col, 1'b0}; col wraps at H_RESOLUTION-1 to 0, then row increments.
  - Credit rule: assert m_read only if fifo_count + outstanding < FIFO_DEPTH. The FIFO can never overflow.
  - Once m_read is asserted with m_waitrequest high, m_read and m_address hold stable until accepted.
  - outstanding increments on accept and decrements on m_readdatavalid. Simultaneous accept and return leave it unchanged.
- Return side:
  - each m_readdatavalid pushes m_readdata into the FIFO in the same cycle (registered write).
  - m_readdatavalid in IDLE is discarded.
- Stream side:
  - pix_valid = FIFO non-empty; pix_data = FIFO head (first-word-fall-through); pop on pix_valid & pix_ready.
  - pix_data and pix_valid hold stable while pix_ready is low.
  - Push and pop in the same cycle: count unchanged; a full FIFO accepts a push only in that case.
  - Latency: first pixel is valid no earlier than 1 cycle after its m_readdatavalid.
- Pixel counters:
  - a separate output-side counter drives pix_sop and pix_eop.
  - H_RESOLUTION = V_RESOLUTION = 1: sop and eop are asserted together.
- start coinciding with done, or arriving while busy, is ignored.

Optional Feature:
CONTINUOUS_SCAN_EN
- Defined:
  - after the eop pixel is accepted, the block restarts from (0,0) at the latched base without a new start. busy stays 1 and done still pulses per frame.
  - start while busy updates the base for the next frame only; the current frame is unaffected.
- Undefined: single-shot behaviour as above.

Test Plan:
- H=4, V=2, base=0x08000000, zero-wait slave, readdatavalid 1 cycle after accept, pix_ready=1 -> addresses 0x08000000,02,04,06,0x08000400,02,04,06. 8 pixels out matching memory; sop on pixel 0, eop on pixel 7; exactly one done pulse; busy low after.
- pix_ready held 0 with FIFO_DEPTH=4 -> at most 4 read requests accepted, then m_read=0; releasing pix_ready completes the frame with data in order.
- m_waitrequest high for 3 cycles on the 2nd request -> m_address=0x08000002 and m_read stable all 3 cycles; no duplicate or skipped address.
- reset_n low for 1 cycle mid-FETCH, with 2 reads outstanding -> all outputs 0 immediately. Late readdatavalid ignored; next start produces a clean frame.
- start pulsed again while busy -> ignored; single done; pixel count = 8.
- CONTINUOUS_SCAN_EN defined, 3 frames -> 3 done pulses, 24 pixels, sop every 8th pixel, busy continuously 1.
